// File: rtl/ethernet_package.sv
// Shared Ethernet framing definitions: receive FSM states, framing bytes
// and the reflected CRC32 step used by both receive and transmit paths.
package ethernet_package;

    typedef enum logic [1:0] {
        FRAME_STATE_HUNT,
        FRAME_STATE_PREAMBLE,
        FRAME_STATE_FRAME,
        FRAME_STATE_DROP
    } frame_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // FCS bytes held back until end of frame decides what they were.
    localparam int DELAY_DEPTH = 4;

    function automatic logic [31:0] crc32_next_byte(
        input logic [31:0] crc,
        input logic [7:0] data_byte
    );
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_byte[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_frame_delay_line.sv
// Short byte shift register that holds back the trailing FCS bytes;
// the oldest byte is valid for popping once the line is full.
module rmii_frame_delay_line
    import ethernet_package::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_byte,
    input  logic       flush,
    output logic       full,
    output logic [7:0] oldest_byte
);

    localparam int COUNT_WIDTH = $clog2(DELAY_DEPTH + 1);

    logic [7:0]             taps [DELAY_DEPTH];
    logic [COUNT_WIDTH-1:0] fill_count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fill_count <= '0;
            for (int i = 0; i < DELAY_DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            if (push) begin
                taps[0] <= push_byte;
                for (int i = 1; i < DELAY_DEPTH; i++) begin
                    taps[i] <= taps[i-1];
                end
            end
            if (flush) begin
                fill_count <= '0;
            end else if (push && !full) begin
                fill_count <= fill_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign full = (fill_count == COUNT_WIDTH'(DELAY_DEPTH));
    assign oldest_byte = taps[DELAY_DEPTH-1];

endmodule

// File: rtl/rmii_frame_checker.sv
// Receive frame stage: locks on preamble/SFD, forwards frame bytes minus
// FCS, checks CRC32 and length, and keeps saturating frame statistics.
module rmii_frame_checker
    import ethernet_package::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [8:0]               packaged_data,
    input  logic                     packaged_data_valid,
    output logic [7:0]               frame_data,
    output logic                     frame_data_valid,
    output logic                     frame_data_last,
    output logic                     frame_status_valid,
    output logic                     frame_status_good,
    output logic                     frame_status_crc_error,
    output logic                     frame_status_length_error,
    output logic [COUNTER_WIDTH-1:0] good_frame_count,
    output logic [COUNTER_WIDTH-1:0] crc_error_count,
    output logic [COUNTER_WIDTH-1:0] length_error_count
);

    localparam int LENGTH_WIDTH = $clog2(MAX_FRAME_BYTES + 2);
    localparam logic [LENGTH_WIDTH-1:0] MIN_LENGTH =
        LENGTH_WIDTH'(MIN_FRAME_BYTES);
    localparam logic [LENGTH_WIDTH-1:0] LENGTH_LIMIT =
        LENGTH_WIDTH'(MAX_FRAME_BYTES + 1);

    frame_state_t            state;
    logic [31:0]             crc_q;
    logic [LENGTH_WIDTH-1:0] length_q;

    logic [7:0]              byte_in;
    logic                    last_in;
    logic                    in_frame;
    logic [LENGTH_WIDTH-1:0] length_next;
    logic [31:0]             crc_next;
    logic                    frame_truncate;
    logic                    frame_end;
    logic                    sfd_seen;
    logic                    preamble_abort;
    logic                    emit;
    logic                    emit_last;
    logic                    status_fire;
    logic                    status_crc_error;
    logic                    status_length_error;
    logic                    status_good;
    logic                    line_push;
    logic                    line_flush;
    logic                    line_full;
    logic [7:0]              line_oldest;

    function automatic logic [COUNTER_WIDTH-1:0] saturating_increment(
        input logic [COUNTER_WIDTH-1:0] value
    );
        return (value == '1) ? value : value + COUNTER_WIDTH'(1);
    endfunction

    assign byte_in = packaged_data[7:0];
    assign last_in = packaged_data[8];
    assign in_frame = packaged_data_valid && (state == FRAME_STATE_FRAME);
    assign length_next = length_q + LENGTH_WIDTH'(1);
    assign crc_next = crc32_next_byte(crc_q, byte_in);

    // Oversize wins over a coincident end marker: the frame is cut either way.
    assign frame_truncate = in_frame && (length_next == LENGTH_LIMIT);
    assign frame_end = in_frame && last_in && !frame_truncate;

    assign sfd_seen = packaged_data_valid
        && (state == FRAME_STATE_PREAMBLE)
        && !last_in && (byte_in == SFD_BYTE);
    assign preamble_abort = packaged_data_valid
        && (state == FRAME_STATE_PREAMBLE)
        && (last_in || ((byte_in != PREAMBLE_BYTE) && (byte_in != SFD_BYTE)));

    assign emit = in_frame && line_full;
    assign emit_last = emit && (frame_end || frame_truncate);

    assign status_fire = preamble_abort || frame_truncate || frame_end;
    assign status_crc_error = frame_end && (crc_next != CRC32_RESIDUE);
    assign status_length_error = preamble_abort || frame_truncate
        || (frame_end && (length_next < MIN_LENGTH));
    assign status_good = status_fire
        && !status_crc_error && !status_length_error;

    assign line_push = in_frame;
    assign line_flush = sfd_seen || frame_end || frame_truncate;

    rmii_frame_delay_line u_delay_line (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (line_push),
        .push_byte   (byte_in),
        .flush       (line_flush),
        .full        (line_full),
        .oldest_byte (line_oldest)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= FRAME_STATE_HUNT;
            crc_q <= CRC32_INIT;
            length_q <= '0;
            frame_data <= '0;
            frame_data_valid <= 1'b0;
            frame_data_last <= 1'b0;
            frame_status_valid <= 1'b0;
            frame_status_good <= 1'b0;
            frame_status_crc_error <= 1'b0;
            frame_status_length_error <= 1'b0;
            good_frame_count <= '0;
            crc_error_count <= '0;
            length_error_count <= '0;
        end else begin
            frame_data_valid <= emit;
            frame_data_last <= emit_last;
            if (emit) begin
                frame_data <= line_oldest;
            end

            frame_status_valid <= status_fire;
            frame_status_good <= status_good;
            frame_status_crc_error <= status_crc_error;
            frame_status_length_error <= status_length_error;

            if (status_good) begin
                good_frame_count <= saturating_increment(good_frame_count);
            end
            if (status_crc_error) begin
                crc_error_count <= saturating_increment(crc_error_count);
            end
            if (status_length_error) begin
                length_error_count <= saturating_increment(length_error_count);
            end

            if (packaged_data_valid) begin
                unique case (state)
                    FRAME_STATE_HUNT: begin
                        if (!last_in) begin
                            state <= (byte_in == PREAMBLE_BYTE)
                                ? FRAME_STATE_PREAMBLE : FRAME_STATE_DROP;
                        end
                    end
                    FRAME_STATE_PREAMBLE: begin
                        if (last_in) begin
                            state <= FRAME_STATE_HUNT;
                        end else if (sfd_seen) begin
                            state <= FRAME_STATE_FRAME;
                            crc_q <= CRC32_INIT;
                            length_q <= '0;
                        end else if (preamble_abort) begin
                            state <= FRAME_STATE_DROP;
                        end
                    end
                    FRAME_STATE_FRAME: begin
                        crc_q <= crc_next;
                        length_q <= length_next;
                        if (frame_truncate) begin
                            state <= last_in
                                ? FRAME_STATE_HUNT : FRAME_STATE_DROP;
                        end else if (frame_end) begin
                            state <= FRAME_STATE_HUNT;
                        end
                    end
                    FRAME_STATE_DROP: begin
                        if (last_in) begin
                            state <= FRAME_STATE_HUNT;
                        end
                    end
                    default: state <= FRAME_STATE_HUNT;
                endcase
            end
        end
    end

endmodule

// File: doc/rmii_frame_checker.md
# rmii_frame_checker

Receive-side frame stage that sits directly downstream of `rmii_byte_packager`: it consumes the packaged 9-bit byte stream, locks onto preamble/SFD, forwards the frame bytes with the 4-byte FCS stripped, and checks CRC32 and length. The outputs are a byte stream with a last marker, a per-frame good/bad status, and saturating error counters for the switch core's receive queue.

## Interface
- `MIN_FRAME_BYTES`, 64: minimum length, SFD-exclusive, FCS-inclusive.
- `MAX_FRAME_BYTES`, 1522: maximum length, same basis.
- `COUNTER_WIDTH`, 16: width of the statistics counters.
- `clock` in 1: single clock domain.
- `reset_n` in 1: synchronous, active-low.
- `packaged_data` in 9: [7:0] byte; [8]=1 marks the final byte of a frame.
- `packaged_data_valid` in 1: byte strobe.
- `frame_data` out 8: forwarded frame byte; FCS excluded.
- `frame_data_valid` out 1: byte strobe.
- `frame_data_last` out 1: final forwarded byte of the frame.
- `frame_status_valid` out 1: one-cycle pulse per frame.
- `frame_status_good` out 1: CRC ok and length in range; meaningful only while `frame_status_valid`=1.
- `frame_status_crc_error` out 1: CRC mismatch.
- `frame_status_length_error` out 1: runt, oversize, or bad preamble.
- `good_frame_count` out COUNTER_WIDTH: count of good frames.
- `crc_error_count` out COUNTER_WIDTH: count of CRC errors.
- `length_error_count` out COUNTER_WIDTH: count of length errors.

## Operation
- The state machine has four states: HUNT, PREAMBLE, FRAME, DROP. The block does nothing on cycles where `packaged_data_valid`=0.
- HUNT: byte 0x55 moves to PREAMBLE. Any other byte moves to DROP, unless [8]=1, in which case it stays in HUNT.
- PREAMBLE: 0x55 stays in PREAMBLE. 0xD5 moves to FRAME and clears the CRC and length counter. Any other byte, or [8]=1, is a length error (status pulse) and moves to DROP, or to HUNT if [8]=1.
- FRAME: each byte is applied to the CRC, the length counter is incremented, and the byte is pushed into a 4-byte delay line. Once the line is full, each push emits the oldest byte. Bytes remaining in the line at end of frame are the FCS and are discarded.
- FRAME end on [8]=1:
  - The oldest delay byte is emitted with `frame_data_last`=1, provided the length is ≥5.
  - The status pulse is emitted.
  - Next state is HUNT.
- FRAME on length reaching MAX_FRAME_BYTES+1: the delay byte is emitted with last=1, the status pulse reports a length error, and the state moves to DROP (HUNT if [8]=1).
- DROP: all bytes are ignored until [8]=1, then the state moves to HUNT.
- CRC32 is reflected: polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first.
- The frame passes CRC when the register after the last FCS byte, before inversion, equals 0xDEBB20E3.
- Length is compared only at end of frame. Length < MIN_FRAME_BYTES sets the length error; the CRC error is still reported independently.
- `frame_status_good` = no CRC error and no length error.
- Counters:
  - Each status pulse increments good, or CRC and/or length.
  - A frame with both errors increments both.
  - Counters saturate at all-ones.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state resets to HUNT.
- Latency: `frame_data` appears one clock after the input byte that pushes it out of the delay line.
- The status pulse coincides with `frame_data_last` when a last byte exists; otherwise it is one clock after the terminating input byte.
- Frames of ≤4 bytes: no data is output, only a status pulse with length error.
- Back-to-back frames, where the next byte follows [8]=1 on the very next valid cycle, are accepted with no gap requirement.
- Reset mid-frame: the delay line, CRC, and length are cleared, no status is emitted, and counters clear to 0.
- Output has no backpressure; downstream must accept one byte per valid cycle.

## Structure
- Shared package `ethernet_package` holds:
  - the frame state enum;
  - constants PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC32_INIT, CRC32_RESIDUE 0xDEBB20E3;
  - the function `crc32_next_byte(crc, byte)`.
- The function is shared with the transmit path.
- One sub-module, `rmii_frame_delay_line`: a 4-deep byte shift register with a fill count and a flush.

## Test plan
- Valid 64-byte frame (7×0x55, 0xD5, 60 payload bytes, correct FCS; the same check the bench's `calc_crc` function performs) -> 60 bytes out, last on byte 60, status good=1, `good_frame_count`=1.
- Same frame with one payload bit flipped -> 60 bytes out, crc_error=1, good=0, `crc_error_count`=1.
- 40-byte frame with correct FCS -> 36 bytes out, length_error=1, crc_error=0.
- 1600-byte frame -> truncated at 1522 with last, length_error=1, remaining bytes dropped; next valid frame checks good.
- Preamble 0x55,0x55,0x12 then 20 bytes ending [8]=1 -> no data, one length-error pulse; the following valid frame is good.
- Reset asserted mid-frame, then a valid frame -> only the second frame's status appears; counters show good=1, others 0. Saturation is checked with COUNTER_WIDTH=2: five good frames -> count=3.
